// File: rtl/read_seq_generator.sv
// Multi-channel read-strobe sequencer: after a detected adc_clk fall it waits a
// programmable delay, then strobes each channel in order. Build option: READ_SEQ_SYNC_EN.
module read_seq_generator #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 4,
  parameter int SLOT_LEN = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int SLOT_W  = $clog2(SLOT_LEN + 1)
) (
  input  logic              f_data_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              adc_clk,
  input  logic [CNT_W-1:0]  delay,
  input  logic              hold_last,
  output logic [NUM_CH-1:0] read_sig,
  output logic [CH_W-1:0]   ch_idx,
  output logic              busy,
  output logic              frame_done,
  output logic              missed,
  output logic [7:0]        miss_cnt
);

  typedef enum logic [1:0] {IDLE, DELAY, READ, HOLD} state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [CNT_W-1:0]    delay_reg, delay_next;
  logic                hold_reg, hold_next;
  logic [CH_W-1:0]     ch_reg, ch_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next;
  logic [NUM_CH-1:0]   read_reg, read_next;
  logic                done_reg, done_next;
  logic                missed_reg, missed_next;
  logic [7:0]          miss_cnt_reg, miss_cnt_next;

  logic                adc_s_reg;
  logic                adc_d_reg;
  logic                adc_fall;

`ifdef READ_SEQ_SYNC_EN
  logic                sync_reg;

  always_ff @(posedge f_data_clk) begin
    if (rst) begin
      sync_reg  <= 1'b0;
      adc_s_reg <= 1'b0;
    end else begin
      sync_reg  <= adc_clk;
      adc_s_reg <= sync_reg;
    end
  end
`else
  // adc_clk already lives in this clock domain; one sampling flop suffices.
  always_ff @(posedge f_data_clk) begin
    if (rst) adc_s_reg <= 1'b0;
    else     adc_s_reg <= adc_clk;
  end
`endif

  always_ff @(posedge f_data_clk) begin
    if (rst) adc_d_reg <= 1'b0;
    else     adc_d_reg <= adc_s_reg;
  end

  assign adc_fall = adc_d_reg & ~adc_s_reg;

  // One-hot pattern for the channel following the current one.
  logic [CH_W-1:0]   ch_inc;
  logic [NUM_CH-1:0] onehot_inc;

  assign ch_inc = ch_reg + 1'b1;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
    assign onehot_inc[gi] = (ch_inc == CH_W'(gi));
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    delay_next    = delay_reg;
    hold_next     = hold_reg;
    ch_next       = ch_reg;
    slot_next     = slot_reg;
    read_next     = read_reg;
    done_next     = 1'b0;
    missed_next   = 1'b0;
    miss_cnt_next = miss_cnt_reg;

    if (!enable) begin
      state_next = IDLE;
      read_next  = '0;
      slot_next  = '0;
    end else if ((state_reg == DELAY || state_reg == READ) && adc_s_reg) begin
      state_next  = IDLE;
      read_next   = '0;
      slot_next   = '0;
      missed_next = 1'b1;
      if (miss_cnt_reg != 8'hFF) miss_cnt_next = miss_cnt_reg + 8'd1;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (adc_fall) begin
            delay_next = delay;
            hold_next  = hold_last;
            ch_next    = '0;
            slot_next  = '0;
            if (delay == '0) begin
              state_next = READ;
            end else begin
              state_next = DELAY;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        DELAY: begin
          if (cnt_reg == delay_reg) state_next = READ;
          else                      cnt_next   = cnt_reg + 1'b1;
        end
        READ: begin
          // slot_reg==0 marks the lead-in cycle before channel 0 is driven.
          if (slot_reg == '0) begin
            read_next = NUM_CH'(1);
            slot_next = SLOT_W'(1);
          end else if (slot_reg != SLOT_W'(SLOT_LEN)) begin
            slot_next = slot_reg + 1'b1;
          end else if (ch_reg == LAST_CH) begin
            slot_next = '0;
            if (hold_reg) begin
              state_next = HOLD;
            end else begin
              state_next = IDLE;
              read_next  = '0;
              done_next  = 1'b1;
            end
          end else begin
            ch_next   = ch_inc;
            read_next = onehot_inc;
            slot_next = SLOT_W'(1);
          end
        end
        HOLD: begin
          if (adc_s_reg) begin
            state_next = IDLE;
            read_next  = '0;
            done_next  = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          read_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge f_data_clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      delay_reg    <= '0;
      hold_reg     <= 1'b0;
      ch_reg       <= '0;
      slot_reg     <= '0;
      read_reg     <= '0;
      done_reg     <= 1'b0;
      missed_reg   <= 1'b0;
      miss_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      delay_reg    <= delay_next;
      hold_reg     <= hold_next;
      ch_reg       <= ch_next;
      slot_reg     <= slot_next;
      read_reg     <= read_next;
      done_reg     <= done_next;
      missed_reg   <= missed_next;
      miss_cnt_reg <= miss_cnt_next;
    end
  end

  assign read_sig   = read_reg;
  assign ch_idx     = ch_reg;
  assign busy       = (state_reg != IDLE);
  assign frame_done = done_reg;
  assign missed     = missed_reg;
  assign miss_cnt   = miss_cnt_reg;

endmodule

// File: tb/tb_read_seq_generator.sv
// Directed bench for read_seq_generator: a 4-channel/2-cycle-slot instance and a
// single-channel legacy instance share one stimulus stream.
module tb_read_seq_generator;

`ifdef READ_SEQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       adc_clk;
  logic [3:0] delay;
  logic       hold_last;

  logic [3:0] rs0;
  logic [1:0] ch0;
  logic       busy0, fd0, ms0;
  logic [7:0] mc0;

  logic [0:0] rs1;
  logic [0:0] ch1;
  logic       busy1, fd1, ms1;
  logic [7:0] mc1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  read_seq_generator #(.NUM_CH(4), .CNT_W(4), .SLOT_LEN(2)) dut0 (
    .f_data_clk(clk), .rst(rst), .enable(enable), .adc_clk(adc_clk),
    .delay(delay), .hold_last(hold_last), .read_sig(rs0), .ch_idx(ch0),
    .busy(busy0), .frame_done(fd0), .missed(ms0), .miss_cnt(mc0)
  );

  read_seq_generator #(.NUM_CH(1), .CNT_W(4), .SLOT_LEN(1)) dut1 (
    .f_data_clk(clk), .rst(rst), .enable(enable), .adc_clk(adc_clk),
    .delay(delay), .hold_last(hold_last), .read_sig(rs1), .ch_idx(ch1),
    .busy(busy1), .frame_done(fd1), .missed(ms1), .miss_cnt(mc1)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; adc_clk = 1'b1; delay = 4'd0; hold_last = 1'b0;
    step(3);
    check("reset_read_sig", 32'(rs0), 32'h0);
    check("reset_ch_idx", 32'(ch0), 32'h0);
    check("reset_busy", 32'(busy0), 32'h0);
    check("reset_done", 32'(fd0), 32'h0);
    check("reset_missed", 32'(ms0), 32'h0);
    check("reset_miss_cnt", 32'(mc0), 32'h0);
    rst = 1'b0; enable = 1'b1;
    step(4);

    // Normal frame: delay=3, slots of 2 cycles, first strobe at T+4.
    delay = 4'd3; hold_last = 1'b0;
    adc_clk = 1'b0;
    step(LAT);
    check("frame_busy_at_T", 32'(busy0), 32'h1);
    check("frame_idle_strobe_T", 32'(rs0), 32'h0);
    step(3);
    check("frame_no_strobe_T3", 32'(rs0), 32'h0);
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 2; s++) begin
        step(1);
        check("frame_strobe", 32'(rs0), 32'(1) << c);
        check("frame_ch_idx", 32'(ch0), 32'(c));
      end
    end
    step(1);
    check("frame_done_T12", 32'(fd0), 32'h1);
    check("frame_strobe_off_T12", 32'(rs0), 32'h0);
    check("frame_busy_off_T12", 32'(busy0), 32'h0);
    step(1);
    check("frame_done_pulse", 32'(fd0), 32'h0);
    check("frame_miss_cnt", 32'(mc0), 32'h0);

    // delay=0 and abort during channel 2's slot.
    adc_clk = 1'b1; step(4);
    delay = 4'd0;
    adc_clk = 1'b0;
    step(LAT);
    check("d0_no_strobe_T", 32'(rs0), 32'h0);
    step(1);
    check("d0_strobe_T1", 32'(rs0), 32'h1);
    step(4);
    check("abort_ch2_slot", 32'(rs0), 32'h4);
    adc_clk = 1'b1;
    step(LAT - 1);
    check("abort_pre_missed", 32'(ms0), 32'h0);
    check("abort_pre_busy", 32'(busy0), 32'h1);
    step(1);
    check("abort_strobe_off", 32'(rs0), 32'h0);
    check("abort_missed", 32'(ms0), 32'h1);
    check("abort_miss_cnt", 32'(mc0), 32'h1);
    check("abort_no_done", 32'(fd0), 32'h0);
    check("abort_busy_off", 32'(busy0), 32'h0);
    step(1);
    check("abort_missed_pulse", 32'(ms0), 32'h0);

    // 254 more aborts bring the count to 255, one more must saturate.
    for (int k = 0; k < 254; k++) begin
      adc_clk = 1'b0; step(LAT + 1);
      adc_clk = 1'b1; step(LAT);
      step(1);
    end
    check("sat_cnt_255", 32'(mc0), 32'hFF);
    adc_clk = 1'b0; step(LAT + 1);
    adc_clk = 1'b1; step(LAT);
    check("sat_missed", 32'(ms0), 32'h1);
    check("sat_cnt_hold", 32'(mc0), 32'hFF);
    step(1);

    // enable dropped mid-DELAY.
    delay = 4'd10;
    adc_clk = 1'b0;
    step(LAT + 3);
    check("en_drop_busy_before", 32'(busy0), 32'h1);
    enable = 1'b0;
    step(1);
    check("en_drop_busy", 32'(busy0), 32'h0);
    check("en_drop_strobe", 32'(rs0), 32'h0);
    check("en_drop_missed", 32'(ms0), 32'h0);
    check("en_drop_done", 32'(fd0), 32'h0);
    check("en_drop_miss_cnt", 32'(mc0), 32'hFF);

    // enable rising on the trigger edge, delay changed after trigger, rst mid-READ.
    adc_clk = 1'b1; step(4);
    adc_clk = 1'b0;
    step(LAT - 1);
    check("en_rise_idle", 32'(busy0), 32'h0);
    enable = 1'b1;
    step(1);
    check("en_rise_trigger", 32'(busy0), 32'h1);
    delay = 4'd2;
    step(10);
    check("latched_delay_T10", 32'(rs0), 32'h0);
    step(1);
    check("latched_delay_T11", 32'(rs0), 32'h1);
    step(2);
    check("rst_pre_strobe", 32'(rs0), 32'h2);
    check("rst_pre_ch", 32'(ch0), 32'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_strobe", 32'(rs0), 32'h0);
    check("rst_ch_idx", 32'(ch0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_missed", 32'(ms0), 32'h0);
    check("rst_miss_cnt", 32'(mc0), 32'h0);

    // delay=15: first strobe at T+16, frame_done at T+24.
    adc_clk = 1'b1; step(4);
    delay = 4'd15;
    adc_clk = 1'b0;
    step(LAT);
    delay = 4'd0;
    step(15);
    check("d15_no_strobe_T15", 32'(rs0), 32'h0);
    check("d15_busy_T15", 32'(busy0), 32'h1);
    step(1);
    check("d15_strobe_T16", 32'(rs0), 32'h1);
    step(7);
    check("d15_last_T23", 32'(rs0), 32'h8);
    step(1);
    check("d15_done_T24", 32'(fd0), 32'h1);
    check("d15_busy_T24", 32'(busy0), 32'h0);

    // Legacy single-strobe with hold, on the single-channel instance.
    adc_clk = 1'b1; step(4);
    delay = 4'd7; hold_last = 1'b1;
    adc_clk = 1'b0;
    step(LAT + 7);
    check("hold_no_strobe_T7", 32'(rs1), 32'h0);
    check("hold_busy_T7", 32'(busy1), 32'h1);
    step(1);
    check("hold_strobe_T8", 32'(rs1), 32'h1);
    step(6);
    check("hold_strobe_held", 32'(rs1), 32'h1);
    check("hold_no_done", 32'(fd1), 32'h0);
    adc_clk = 1'b1;
    step(LAT - 1);
    check("hold_before_release", 32'(rs1), 32'h1);
    step(1);
    check("hold_release", 32'(rs1), 32'h0);
    check("hold_done", 32'(fd1), 32'h1);
    check("hold_busy_off", 32'(busy1), 32'h0);
    check("hold_no_missed", 32'(ms1), 32'h0);
    step(1);
    check("hold_done_pulse", 32'(fd1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
